// File: rtl/fetch_pkg.sv
// Shared definitions for the PC / instruction-fetch stage: state encoding,
// default PC increment and word-alignment helpers.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] PC_STEP_DEF     = 32'd4;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic is_aligned(input logic [31:0] addr);
        return ((addr & ~WORD_ALIGN_MASK) == 32'd0);
    endfunction

endpackage

// File: rtl/pc_incr.sv
// Sequential PC incrementer: a + STEP with the carry out discarded, so the
// address space wraps silently at 2^32.
module pc_incr
    import fetch_pkg::*;
#(
    parameter logic [31:0] STEP = PC_STEP_DEF
) (
    input  logic [31:0] a,
    output logic [31:0] y
);

    assign y = a + STEP;

endmodule

// File: rtl/pc_fetch_stage.sv
// Program-counter / instruction-fetch stage: one outstanding imem request,
// valid/ready hand-off to decode, redirect support, sticky error flags.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module pc_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEF
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYC = 16
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_next,
    output logic [31:0] if_instr,
    output logic        misalign,
    output logic        timeout
);

    fetch_state_e state_r, state_s;
    logic [31:0]  pc_r, pc_s;
    logic [31:0]  instr_r, instr_s;
    logic [31:0]  pc_plus_s;
    logic         misalign_r, misalign_s;
    logic         timeout_r, timeout_s;

`ifdef FETCH_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] cnt_r, cnt_s;
`endif

    pc_incr #(
        .STEP (PC_STEP)
    ) u_pc_incr (
        .a (pc_r),
        .y (pc_plus_s)
    );

    // Next-state logic: redirect overrides everything except the halt state.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        instr_s    = instr_r;
        misalign_s = misalign_r;
        timeout_s  = timeout_r;
        if ((state_r != S_HALT) && redirect) begin
            if (is_aligned(redirect_pc)) begin
                pc_s    = redirect_pc;
                state_s = S_REQ;
            end else begin
                misalign_s = 1'b1;
                state_s    = S_HALT;
            end
        end else begin
            case (state_r)
                S_IDLE: state_s = S_REQ;
                S_REQ: begin
                    if (imem_ack) begin
                        instr_s = imem_rdata;
                        state_s = S_HOLD;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (cnt_r == CNT_LAST) begin
                        timeout_s = 1'b1;
                        state_s   = S_HALT;
                    end
`endif
                    else begin
                        state_s = S_REQ;
                    end
                end
                S_HOLD: begin
                    if (if_ready) begin
                        pc_s    = pc_plus_s;
                        state_s = S_REQ;
                    end else begin
                        state_s = S_HOLD;
                    end
                end
                S_HALT:  state_s = S_HALT;
                default: state_s = S_IDLE;
            endcase
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Watchdog counts only uninterrupted S_REQ cycles; any ack, redirect or exit clears it.
    always_comb begin
        if ((state_r == S_REQ) && (state_s == S_REQ) && !redirect) begin
            cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_s = {CNT_W{1'b0}};
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_s;
        end
    end
`endif

    // State, PC, held instruction and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            pc_r       <= RESET_PC;
            instr_r    <= 32'd0;
            misalign_r <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            instr_r    <= instr_s;
            misalign_r <= misalign_s;
            timeout_r  <= timeout_s;
        end
    end

    assign imem_req   = (state_r == S_REQ);
    assign imem_addr  = pc_r;
    assign if_valid   = (state_r == S_HOLD);
    assign if_pc      = pc_r;
    assign if_pc_next = pc_plus_s;
    assign if_instr   = instr_r;
    assign misalign   = misalign_r;
    assign timeout    = timeout_r;

endmodule
